// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU operation codes,
// the EX-stage control bundle and a register-match helper used by the
// forwarding and hazard logic.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_AND = 5'b11100;
    localparam logic [4:0] ALU_XOR = 5'b10000;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRL = 5'b10100;
    localparam logic [4:0] ALU_SRA = 5'b10110;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic       a_pc;
        logic       b_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ex_ctrl_t;

    // True when a writing stage targets source register rs; x0 never matches.
    function automatic logic reg_hit(input logic            we,
                                     input logic [RA_W-1:0] wr_rd,
                                     input logic [RA_W-1:0] rs);
        return we && (rs != '0) && (rs == wr_rd);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the later pipeline stages and the ID/EX stage.
// master = the surrounding pipeline (drives decode and bypass values),
// slave  = id_ex_stage (drives ALU operands, EX control and hazard_stall).
interface id_ex_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
);

    logic            id_valid;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [4:0]      id_alu_sel;
    logic            id_a_pc;
    logic            id_b_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;

    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [RA_W-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;

    logic            hazard_stall;
    logic            ex_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_sel;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    modport master (
        output id_valid, stall, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_sel, id_a_pc, id_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        input  hazard_stall, ex_valid, alu_a, alu_b, alu_sel, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, stall, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_sel, id_a_pc, id_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        output hazard_stall, ex_valid, alu_a, alu_b, alu_sel, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand bypass mux: picks the MEM result, else the WB result, else the
// value held in the ID/EX register. Only built when FORWARDING_EN is defined.
`ifdef FORWARDING_EN
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_val,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_val
);

    // MEM holds the younger write, so it wins over WB for the same register
    always_comb begin
        fwd_val = reg_val;
        if (reg_hit(mem_reg_write, mem_rd, rs)) begin
            fwd_val = mem_result;
        end else if (reg_hit(wb_reg_write, wb_rd, rs)) begin
            fwd_val = wb_result;
        end
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbling.
// Build option FORWARDING_EN: when defined, rs1/rs2 are bypassed from MEM/WB
// and only load-use hazards stall; when undefined, no bypass exists and decode
// stalls on any pending write in EX or MEM (the register file is write-first,
// so WB needs no check).
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic [RA_W-1:0] rd_q;
    ex_ctrl_t        ctrl_q;
    ex_ctrl_t        id_ctrl;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;

    assign id_ctrl = '{alu_sel:   bus.id_alu_sel,
                       a_pc:      bus.id_a_pc,
                       b_imm:     bus.id_b_imm,
                       reg_write: bus.id_reg_write,
                       mem_read:  bus.id_mem_read,
                       mem_write: bus.id_mem_write};

`ifdef FORWARDING_EN
    fwd_unit u_fwd_rs1 (
        .rs            (rs1_q),
        .reg_val       (rs1_data_q),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .mem_result    (bus.mem_result),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_result     (bus.wb_result),
        .fwd_val       (fwd_rs1)
    );

    fwd_unit u_fwd_rs2 (
        .rs            (rs2_q),
        .reg_val       (rs2_data_q),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .mem_result    (bus.mem_result),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_result     (bus.wb_result),
        .fwd_val       (fwd_rs2)
    );

    // A load in EX cannot forward in time; unused operands are compared too
    assign hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && bus.id_valid &&
                    ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));
`else
    logic unused_bypass;

    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;

    // Without bypass, wait until every pending EX/MEM write has reached the register file
    assign hazard = bus.id_valid &&
                    (reg_hit(valid_q && ctrl_q.reg_write, rd_q, bus.id_rs1) ||
                     reg_hit(valid_q && ctrl_q.reg_write, rd_q, bus.id_rs2) ||
                     reg_hit(bus.mem_reg_write, bus.mem_rd, bus.id_rs1)    ||
                     reg_hit(bus.mem_reg_write, bus.mem_rd, bus.id_rs2));

    assign unused_bypass = ^{rs1_q, rs2_q, bus.mem_result, bus.wb_rd,
                             bus.wb_reg_write, bus.wb_result};
`endif

    // Pipeline register: reset, then flush, stall (with operand refresh), hazard bubble, capture
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (bus.stall) begin
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
        end else if (hazard) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q    <= bus.id_valid;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            ctrl_q     <= id_ctrl;
        end
    end

    // Operand selection and EX control; control is gated so bubbles never write
    always_comb begin
        bus.hazard_stall  = hazard;
        bus.ex_valid      = valid_q;
        bus.alu_a         = ctrl_q.a_pc  ? pc_q  : fwd_rs1;
        bus.alu_b         = ctrl_q.b_imm ? imm_q : fwd_rs2;
        bus.alu_sel       = ctrl_q.alu_sel;
        bus.ex_store_data = fwd_rs2;
        bus.ex_rd         = rd_q;
        bus.ex_reg_write  = valid_q & ctrl_q.reg_write;
        bus.ex_mem_read   = valid_q & ctrl_q.mem_read;
        bus.ex_mem_write  = valid_q & ctrl_q.mem_write;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. Expectations follow FORWARDING_EN the
// same way the design does, so the bench is valid for either build.
module tb_id_ex_stage;
    import riscv_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd, alu_sel;
        logic        a_pc, b_imm, reg_write, mem_read, mem_write;
    } id_t;

    typedef struct packed {
        logic [4:0]  mem_rd;
        logic        mem_rw;
        logic [31:0] mem_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_res;
    } byp_t;

    typedef struct packed {
        logic        dp;
        logic        valid;
        logic [31:0] a, b, st;
        logic [4:0]  sel, rd;
        logic        rw, mr, mw, haz;
    } exp_t;

    typedef struct packed {
        logic stall, flush;
        id_t  id;
        byp_t byp;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic id_t mk_id(input logic [31:0] pc, rs1_data, rs2_data, imm,
                                  input logic [4:0] rs1, rs2, rd, sel,
                                  input logic a_pc, b_imm, rw, mr, mw);
        id_t r;
        r.valid = 1'b1; r.pc = pc; r.rs1_data = rs1_data; r.rs2_data = rs2_data;
        r.imm = imm; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.alu_sel = sel;
        r.a_pc = a_pc; r.b_imm = b_imm; r.reg_write = rw; r.mem_read = mr; r.mem_write = mw;
        return r;
    endfunction

    function automatic byp_t mk_byp(input logic [4:0] mem_rd, input logic mem_rw, input logic [31:0] mem_res,
                                    input logic [4:0] wb_rd, input logic wb_rw, input logic [31:0] wb_res);
        byp_t r;
        r.mem_rd = mem_rd; r.mem_rw = mem_rw; r.mem_res = mem_res;
        r.wb_rd = wb_rd; r.wb_rw = wb_rw; r.wb_res = wb_res;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic dp, valid, input logic [31:0] a, b, st,
                                    input logic [4:0] sel, rd, input logic rw, mr, mw, haz);
        exp_t r;
        r.dp = dp; r.valid = valid; r.a = a; r.b = b; r.st = st; r.sel = sel; r.rd = rd;
        r.rw = rw; r.mr = mr; r.mw = mw; r.haz = haz;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic stall, flush, input id_t id, input byp_t byp, input exp_t e);
        vec_t r;
        r.stall = stall; r.flush = flush; r.id = id; r.byp = byp; r.e = e;
        return r;
    endfunction

    // Drive every DUT input for one cycle
    task automatic applyStimulus(input logic rst, input vec_t v);
        reset             = rst;
        bus.stall         = v.stall;
        bus.flush         = v.flush;
        bus.id_valid      = v.id.valid;
        bus.id_pc         = v.id.pc;
        bus.id_rs1_data   = v.id.rs1_data;
        bus.id_rs2_data   = v.id.rs2_data;
        bus.id_imm        = v.id.imm;
        bus.id_rs1        = v.id.rs1;
        bus.id_rs2        = v.id.rs2;
        bus.id_rd         = v.id.rd;
        bus.id_alu_sel    = v.id.alu_sel;
        bus.id_a_pc       = v.id.a_pc;
        bus.id_b_imm      = v.id.b_imm;
        bus.id_reg_write  = v.id.reg_write;
        bus.id_mem_read   = v.id.mem_read;
        bus.id_mem_write  = v.id.mem_write;
        bus.mem_rd        = v.byp.mem_rd;
        bus.mem_reg_write = v.byp.mem_rw;
        bus.mem_result    = v.byp.mem_res;
        bus.wb_rd         = v.byp.wb_rd;
        bus.wb_reg_write  = v.byp.wb_rw;
        bus.wb_result     = v.byp.wb_res;
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s %s: got 0x%0h required 0x%0h", tag, what, act, req);
        end
    endtask

    // Compare DUT outputs; datapath fields only where the row says they are defined
    task automatic checkOutput(input string tag, input exp_t e);
        chk(tag, "ex_valid",     32'(bus.ex_valid),     32'(e.valid));
        chk(tag, "ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
        chk(tag, "ex_mem_read",  32'(bus.ex_mem_read),  32'(e.mr));
        chk(tag, "ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
        chk(tag, "hazard_stall", 32'(bus.hazard_stall), 32'(e.haz));
        if (e.dp) begin
            chk(tag, "alu_a",         bus.alu_a,           e.a);
            chk(tag, "alu_b",         bus.alu_b,           e.b);
            chk(tag, "alu_sel",       32'(bus.alu_sel),    32'(e.sel));
            chk(tag, "ex_store_data", bus.ex_store_data,   e.st);
            chk(tag, "ex_rd",         32'(bus.ex_rd),      32'(e.rd));
        end
    endtask

    // Directed test: reset, vector table, then reset asserted during a stall
    initial begin
        id_t  i1, i2, i3, i4, i5, i6, i7, i8;
        byp_t zb;
        exp_t zero_e, bub_e, st_e;
        vec_t vecs[15];

        i1 = mk_id(32'h100, 32'h5,    32'h9,  32'h7,  5'd1, 5'd2, 5'd10, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        i2 = mk_id(32'h200, 32'h11,   32'h22, 32'h40, 5'd3, 5'd5, 5'd8,  ALU_SUB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        i3 = mk_id(32'h300, 32'h33,   32'h44, 32'h8,  5'd3, 5'd4, 5'd7,  ALU_AND, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        i4 = mk_id(32'h400, 32'h55,   32'h66, 32'h10, 5'd0, 5'd2, 5'd9,  ALU_XOR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        i5 = mk_id(32'h600, 32'h1000, 32'h0,  32'h4,  5'd1, 5'd0, 5'd4,  ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        i6 = mk_id(32'h700, 32'h70,   32'h0,  32'h0,  5'd5, 5'd4, 5'd11, ALU_SLL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        i7 = mk_id(32'h800, 32'h2000, 32'h0,  32'hC,  5'd1, 5'd6, 5'd0,  ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        i8 = mk_id(32'h900, 32'h21,   32'h31, 32'h5,  5'd2, 5'd3, 5'd12, ALU_SRA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        zb     = mk_byp(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        zero_e = mk_exp(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bub_e  = mk_exp(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        st_e   = mk_exp(1'b1, 1'b1, 32'h2000, 32'hC, FWD ? 32'h1234 : 32'h0, ALU_ADD, 5'd0,
                        1'b0, 1'b0, 1'b1, 1'b0);

        vecs[0]  = mk_vec(1'b0, 1'b0, i2, zb, zero_e);
        vecs[1]  = mk_vec(1'b0, 1'b0, i2, zb,
                          mk_exp(1'b1, 1'b1, 32'h5, 32'h7, 32'h9, ALU_ADD, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[2]  = mk_vec(1'b0, 1'b0, i3, zb,
                          mk_exp(1'b1, 1'b1, 32'h200, 32'h22, 32'h22, ALU_SUB, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[3]  = mk_vec(1'b1, 1'b0, i4, mk_byp(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB),
                          mk_exp(1'b1, 1'b1, FWD ? 32'hAA : 32'h33, 32'h44, 32'h44, ALU_AND, 5'd7,
                                 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[4]  = mk_vec(1'b1, 1'b0, i4, mk_byp(5'd3, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB),
                          mk_exp(1'b1, 1'b1, FWD ? 32'hBB : 32'h33, 32'h44, 32'h44, ALU_AND, 5'd7,
                                 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[5]  = mk_vec(1'b0, 1'b0, i4, zb,
                          mk_exp(1'b1, 1'b1, FWD ? 32'hBB : 32'h33, 32'h44, 32'h44, ALU_AND, 5'd7,
                                 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[6]  = mk_vec(1'b0, 1'b0, i5, mk_byp(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB),
                          mk_exp(1'b1, 1'b1, 32'h55, 32'h10, 32'h66, ALU_XOR, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[7]  = mk_vec(1'b0, 1'b0, i6, zb,
                          mk_exp(1'b1, 1'b1, 32'h1000, 32'h4, 32'h0, ALU_ADD, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1));
        vecs[8]  = mk_vec(1'b0, 1'b0, i6, mk_byp(5'd4, 1'b1, 32'hDEAD, 5'd0, 1'b0, 32'h0),
                          mk_exp(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, !FWD));
        vecs[9]  = mk_vec(1'b0, 1'b0, i6, mk_byp(5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'hDEAD),
                          mk_exp(FWD, FWD, 32'h70, 32'hDEAD, 32'hDEAD, ALU_SLL, 5'd11, FWD, 1'b0, 1'b0, 1'b0));
        vecs[10] = mk_vec(1'b0, 1'b0, i7, zb,
                          mk_exp(1'b1, 1'b1, 32'h70, 32'h0, 32'h0, ALU_SLL, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[11] = mk_vec(1'b1, 1'b0, i8, mk_byp(5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'h1234), st_e);
        vecs[12] = mk_vec(1'b1, 1'b0, i8, zb, st_e);
        vecs[13] = mk_vec(1'b1, 1'b1, i8, zb, st_e);
        vecs[14] = mk_vec(1'b0, 1'b0, i8, zb, bub_e);

        $display("[TB] start, FORWARDING_EN=%0d", FWD);

        applyStimulus(1'b1, mk_vec(1'b0, 1'b0, i1, zb, zero_e));
        @(posedge clk); #1;
        #2 checkOutput("reset_c1", zero_e);
        @(posedge clk); #1;
        #2 checkOutput("reset_c2", zero_e);

        applyStimulus(1'b0, mk_vec(1'b0, 1'b0, i1, zb, zero_e));
        #2 checkOutput("row0", vecs[0].e);
        @(posedge clk); #1;

        for (int i = 1; i < 15; i++) begin
            applyStimulus(1'b0, vecs[i]);
            #2 checkOutput($sformatf("row%0d", i), vecs[i].e);
            @(posedge clk); #1;
        end

        applyStimulus(1'b1, mk_vec(1'b1, 1'b0, i8, zb, zero_e));
        #2 checkOutput("rst_stall_pre",
                       mk_exp(1'b1, 1'b1, 32'h900, 32'h5, 32'h31, ALU_SRA, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        #2 checkOutput("rst_stall_post", zero_e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
